// File: rtl/wb_single_master.sv
// Single-outstanding Wishbone classic master: takes one request at a time, runs one bus cycle, and returns a one-cycle response.
// Optional no-ack timeout is compiled in with `define WB_MASTER_TIMEOUT_EN.
module wb_single_master #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  localparam int SW     = DW / 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          sdr_init_done,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [SW-1:0] req_sel,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [SW-1:0] wb_sel_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          accept;
  logic          ack_in_bus;
  logic          timeout_hit;
  logic          bus_done;
  logic          we_q;
  logic [SW-1:0] sel_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dat_q;
  logic [DW-1:0] rdata_q;

  assign req_ready  = (state_q == IDLE) & sdr_init_done & ~wb_rst_i;
  assign accept     = req_valid & req_ready;
  assign ack_in_bus = (state_q == BUS) & wb_ack_i;
  assign bus_done   = ack_in_bus | timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [7:0] wait_cnt;
  logic       err_q;

  // Ack wins over timeout when both land in the same cycle.
  assign timeout_hit = (state_q == BUS) & ~wb_ack_i & (wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      if (accept)
        wait_cnt <= 8'd0;
      else if ((state_q == BUS) && !wb_ack_i && !timeout_hit)
        wait_cnt <= wait_cnt + 8'd1;
      err_q <= timeout_hit;
    end
  end

  assign rsp_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUS;
      BUS:     if (bus_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // we/sel are only non-zero while the bus cycle is live; adr/dat keep their last value.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q  <= req_we;
        sel_q <= req_sel;
        adr_q <= req_addr;
        dat_q <= req_wdata;
      end else if (bus_done) begin
        we_q  <= 1'b0;
        sel_q <= '0;
      end
      if (ack_in_bus && !we_q)
        rdata_q <= wb_dat_i;
    end
  end

  assign wb_cyc_o  = (state_q == BUS) & ~wb_rst_i;
  assign wb_stb_o  = (state_q == BUS) & ~wb_rst_i;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign rsp_valid = (state_q == RESP) & ~wb_rst_i;
  assign rsp_rdata = rdata_q;

endmodule
